router_ctrl: RTL
================

# router_ctrl

Packet-level controller for the 1x3 router. It accepts byte-serial packets from the source, decodes the 2-bit destination from the header, and sequences writes into the three output FIFOs. Its duties:
- drive each FIFO's `write_enb` and the header-marking `lfd_state`;
- back-pressure the source;
- check parity and payload length;
- soft-reset any output FIFO whose reader stalls.

It sits between the input port and the three router FIFO instances.

## Interface
- `TIMEOUT`, 30: idle-reader cycles before a soft reset of that FIFO.
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `pkt_valid` in 1: high with header and payload bytes; low with the parity byte.
- `data_in` in 8: packet byte from source.
- `fifo_full` in 3: full flags of FIFO2..0.
- `fifo_empty` in 3: empty flags of FIFO2..0.
- `read_enb` in 3: reader read enables, per FIFO.
- `data_out` out 8: byte to all FIFOs.
- `write_enb` out 3: one-hot write enable.
- `lfd_state` out 1: high only while the header is written.
- `busy` out 1: source must hold `data_in` / `pkt_valid` while high.
- `vld_out` out 3: equals `~fifo_empty`.
- `soft_reset` out 3: one-cycle FIFO flush pulses.
- `err` out 1: one-cycle packet error pulse.

## Operation
- Header format: `[7:2]` payload length L (0..63), `[1:0]` destination; address 3 is invalid.
- States: IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK, DROP.
- All outputs except `vld_out` and `soft_reset` are combinational from state, registers and inputs.

State behaviour:
- IDLE: `busy`=0. On an edge with `pkt_valid`=1, capture the header into `hdr_reg` and set `parity_acc` = header, `cnt` = 0. Next state:
  - DROP if addr = 3;
  - LOAD_FIRST if `fifo_empty[addr]`;
  - WAIT_EMPTY otherwise.
- WAIT_EMPTY: `busy`=1, no writes. Go to LOAD_FIRST on the first edge with `fifo_empty[addr]`=1.
- LOAD_FIRST: `busy`=1, `data_out`=`hdr_reg`, `write_enb[addr]`=1, `lfd_state`=1. Go to LOAD_DATA.
- LOAD_DATA: `data_out`=`data_in`, `busy`=`fifo_full[addr]`, `write_enb[addr]`=`~fifo_full[addr]`.
  - Accepted byte with `pkt_valid`=1: payload; `parity_acc ^= data_in`, `cnt`++ (6-bit, saturating at 63).
  - Accepted byte with `pkt_valid`=0: parity byte; it is written and the state goes to CHECK. The error flag is registered as (`parity_acc != data_in`) OR (`cnt != hdr_reg[7:2]`).
  - While full: stay, nothing written or accumulated.
- CHECK: `busy`=1, `err` = registered flag for this one cycle. Go to IDLE.
- DROP: `busy`=0, no writes, bytes discarded. Go to IDLE on the edge that accepts a `pkt_valid`=0 byte (the parity byte).
- A `soft_reset[addr]` pulse in WAIT_EMPTY, LOAD_FIRST or LOAD_DATA forces the next state to DROP. No `err` is raised; the rest of the packet is discarded.
- Only one packet is in flight; the source may start the next header in the cycle after CHECK or DROP exits.

## Timing
- Reset values: state IDLE, all registers 0, `write_enb`=0, `lfd_state`=0, `busy`=0, `soft_reset`=0, `err`=0, `data_out`=0.
- Reset asserted mid-packet aborts the packet immediately; nothing more is written.
- Cycle sequence for an L-byte packet to an empty FIFO:
  - cycle 0: header captured;
  - cycle 1: header written;
  - cycles 2..L+1: payload;
  - cycle L+2: parity written;
  - cycle L+3: CHECK, `err` valid.
- Total L+4 cycles; the next header is accepted in cycle L+4.
- Each full cycle adds one cycle. WAIT_EMPTY adds one cycle per cycle that `fifo_empty[addr]`=0.
- Header written while `fifo_full` is high is impossible, because entry to LOAD_FIRST requires empty.

## Configuration
- `ROUTER_TIMEOUT_EN` defined: one counter per FIFO.
  - The counter clears when `read_enb[i]` or `fifo_empty[i]` is high, otherwise it increments.
  - On reaching `TIMEOUT`, `soft_reset[i]`=1 for one cycle and the counter clears.
  - `soft_reset` is registered.
- `ROUTER_TIMEOUT_EN` undefined: `soft_reset`=0 constantly, no counters, the abort-to-DROP path is absent.

## Test plan
- Header 0x11 (L=4, addr 1), payload A1 B2 C3 D4, parity 0x15, FIFO1 empty -> `write_enb`=3'b010 for 6 cycles, `lfd_state` only with 0x11, `err`=0, back in IDLE at cycle 8.
- Same packet with parity 0x00 -> 6 writes, `err`=1 for exactly one cycle at cycle 7.
- Header 0x13 (addr 3) plus 4 bytes and parity -> `write_enb` never high, `busy`=0 throughout, IDLE after the parity byte.
- Header 0x0A (L=2, addr 2) with `fifo_empty[2]`=0 for 5 cycles -> `busy`=1, no writes. Header written the cycle after `fifo_empty[2]` rises.
- `fifo_full[1]` high for 3 cycles mid-payload -> `busy`=1 and `write_enb`=0 for those cycles, no byte lost, `err`=0. Header L=4 with 3 payload bytes -> `err`=1.
- `ROUTER_TIMEOUT_EN`, FIFO0 non-empty, `read_enb[0]`=0 -> `soft_reset[0]` pulses once after 30 cycles. With `read_enb[0]` pulsed at cycle 29 -> no pulse. If FIFO0 is the active destination, the packet goes to DROP.

Source files
------------

// File: rtl/router_ctrl.sv
// router_ctrl: 1x3 router packet controller; define ROUTER_TIMEOUT_EN for per-FIFO reader-stall soft resets
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [7:0] data_out,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       busy,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK, DROP} state_t;
  state_t state_q, state_d;
  logic [7:0] hdr_q, hdr_d, par_q, par_d;
  logic [5:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [2:0] sel, in_sel;
  logic full, abort;
  assign sel = 3'b001 << hdr_q[1:0];
  assign in_sel = 3'b001 << data_in[1:0];
  assign full = |(fifo_full & sel);
  assign vld_out = ~fifo_empty;
`ifdef ROUTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q [3];
  logic [2:0] sr_q;
  // per-FIFO idle-reader counters; a registered one-cycle pulse flushes a FIFO whose reader stalled
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 3; i++) to_q[i] <= '0;
      sr_q <= '0;
    end else
      for (int i = 0; i < 3; i++) begin
        sr_q[i] <= ~(read_enb[i] | fifo_empty[i]) & (to_q[i] == TW'(TIMEOUT - 1));
        to_q[i] <= (read_enb[i] | fifo_empty[i] | (to_q[i] == TW'(TIMEOUT - 1))) ? '0 : to_q[i] + 1'b1;
      end
  assign soft_reset = sr_q;
  assign abort = |(sr_q & sel);
`else
  logic unused_to;
  assign unused_to = ^{read_enb, 1'(TIMEOUT)};
  assign soft_reset = '0;
  assign abort = 1'b0;
`endif
  // packet state and header/parity/length bookkeeping
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      hdr_q <= '0;
      par_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q <= hdr_d;
      par_q <= par_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  // next-state decode and combinational FIFO write / handshake outputs
  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    par_d = par_q;
    cnt_d = cnt_q;
    err_d = err_q;
    data_out = '0;
    write_enb = '0;
    lfd_state = 1'b0;
    busy = 1'b0;
    err = 1'b0;
    case (state_q)
      IDLE: if (pkt_valid) begin
        hdr_d = data_in;
        par_d = data_in;
        cnt_d = '0;
        state_d = (data_in[1:0] == 2'd3) ? DROP : |(fifo_empty & in_sel) ? LOAD_FIRST : WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        state_d = |(fifo_empty & sel) ? LOAD_FIRST : WAIT_EMPTY;
      end
      LOAD_FIRST: begin
        busy = 1'b1;
        data_out = hdr_q;
        write_enb = sel;
        lfd_state = 1'b1;
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        data_out = data_in;
        busy = full;
        write_enb = full ? '0 : sel;
        if (!full && pkt_valid) begin
          par_d = par_q ^ data_in;
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
        if (!full && !pkt_valid) begin
          err_d = (par_q != data_in) || (cnt_q != hdr_q[7:2]);
          state_d = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        err = err_q;
        state_d = IDLE;
      end
      DROP: state_d = pkt_valid ? DROP : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q inside {WAIT_EMPTY, LOAD_FIRST, LOAD_DATA})) state_d = DROP;
  end
endmodule
